p2s_row_scheduler: RTL and testbench
====================================

P2S_ROW_SCHEDULER -- requirements
Module: p2s_row_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one coefficient.
REQ-002 Parameter ROWS_PER_BLOCK, default 8, rows per 8x8 block.
REQ-003 I_clk  input  1  single clock; all state on rising edge.
REQ-004 I_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 I_en  input  1  global enable; low freezes all state.
REQ-006 I_row_valid  input  1  upstream row of 8 coefficients present.
REQ-007 I_row_d  input  8*DATA_WIDTH  row data; coefficient k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 O_row_ready  output  1  row accepted this cycle when high with I_row_valid.
REQ-009 O_push  output  1  one-cycle load strobe to downstream 8-to-1 serializer.
REQ-010 O_row_q  output  8*DATA_WIDTH  row presented to serializer, valid with O_push.
REQ-011 O_slot  output  3  index of coefficient currently leaving the serializer.
REQ-012 O_block_first  output  1  high with O_push for row 0 of a block.
REQ-013 O_block_last  output  1  high with O_push for row ROWS_PER_BLOCK-1.
REQ-014 O_block_done  output  1  one-cycle pulse after the last slot of the last row.
REQ-015 O_busy  output  1  high while FIFO is non-empty or state is SHIFT.

Function
REQ-016 The block SHALL hold a 2-entry row FIFO; a handshake SHALL occur when I_en, I_row_valid and O_row_ready are all high.
REQ-017 O_row_ready SHALL equal I_en AND (FIFO count < 2), combinational; it SHALL NOT depend on I_row_valid.
REQ-018 The FSM SHALL have states IDLE and SHIFT; reset state IDLE.
REQ-019 A push SHALL be issued when the FIFO is non-empty and (state IDLE, or state SHIFT with O_slot==7).
REQ-020 On a push the FIFO head SHALL be popped, registered onto O_row_q, O_push set for exactly one enabled cycle, O_slot set to 0 and state set to SHIFT.
REQ-021 In SHIFT without a push, O_slot SHALL increment by 1 each enabled cycle; at O_slot==7 with an empty FIFO, state SHALL return to IDLE and O_slot SHALL hold 7.
REQ-022 Consecutive pushes SHALL be spaced exactly 8 enabled cycles apart when the FIFO stays non-empty (gap-free serial stream).
REQ-023 Latency: row accepted in enabled cycle N with FIFO empty and state IDLE SHALL produce O_push in cycle N+1.
REQ-024 Simultaneous accept and pop in one cycle SHALL leave count unchanged; accept into a full FIFO SHALL be impossible since ready is low.
REQ-025 A 3-bit row counter SHALL increment modulo ROWS_PER_BLOCK on every push; O_block_first/O_block_last SHALL be registered with O_push from its pre-increment value.
REQ-026 O_block_done SHALL pulse for one enabled cycle when O_slot advances past 7 (returns to IDLE or re-pushes) for a row issued with O_block_last.
REQ-027 While I_en is low, all registers including O_push, O_block_done and O_slot SHALL hold their values and no handshake SHALL occur.

Reset
REQ-028 On I_rst_n low, all outputs SHALL go immediately to 0 (O_row_q=0, O_slot=0, O_push=0, O_busy=0), FIFO count and row counter to 0, state IDLE.
REQ-029 Reset asserted mid-row or mid-block SHALL discard FIFO contents and the partial block; the first push after reset SHALL carry O_block_first=1.
REQ-030 O_row_ready SHALL be 0 while I_rst_n is low.

Verification
REQ-031 Single row 0x0001..0x0008 accepted in cycle 0, I_en=1 -> O_push in cycle 1 only, O_slot 0..7 in cycles 1..8, IDLE at cycle 9, O_busy low from cycle 9.
REQ-032 Continuous I_row_valid for 16 rows -> pushes exactly every 8 cycles, O_block_first on pushes 1 and 9, O_block_last on pushes 8 and 16, O_block_done one cycle each after slot 7 of rows 8 and 16.
REQ-033 Upstream valid every cycle -> O_row_ready low after 2 entries buffered, one row accepted per push; no row lost or duplicated (scoreboard).
REQ-034 I_en low for 5 cycles at O_slot==3 -> O_slot, O_row_q, count frozen; O_slot resumes at 4; push spacing stretched by exactly 5 cycles.
REQ-035 Reset pulse at row 5 slot 2 with FIFO full -> all outputs 0 asynchronously; next accepted row pushed with O_block_first=1, O_slot=0.
REQ-036 Accept and push in the same cycle with count==1 -> count stays 1, O_row_ready stays high.

Source files
------------

// File: rtl/p2s_row_scheduler.sv
// Row scheduler for an 8-to-1 coefficient serializer: buffers up to two rows
// and issues one load strobe every eight enabled cycles, tracking block position.
module p2s_row_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int ROWS_PER_BLOCK = 8
) (
    input  logic                      I_clk,
    input  logic                      I_rst_n,
    input  logic                      I_en,
    input  logic                      I_row_valid,
    input  logic [8*DATA_WIDTH-1:0]   I_row_d,
    output logic                      O_row_ready,
    output logic                      O_push,
    output logic [8*DATA_WIDTH-1:0]   O_row_q,
    output logic [2:0]                O_slot,
    output logic                      O_block_first,
    output logic                      O_block_last,
    output logic                      O_block_done,
    output logic                      O_busy
);

    localparam int RW = 8 * DATA_WIDTH;
    localparam logic [2:0] LAST_ROW = 3'(ROWS_PER_BLOCK - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     mem_q [2];
    logic [RW-1:0]     mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [2:0]        row_cnt_q, row_cnt_d;
    logic              cur_last_q, cur_last_d;
    logic              push_q, push_d;
    logic [RW-1:0]     row_q, row_d;
    logic [2:0]        slot_q, slot_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    logic              accept;
    logic              issue;
    logic              bypass;
    logic              fifo_wr;
    logic              fifo_rd;
    logic [RW-1:0]     head;

    assign O_row_ready   = I_rst_n & I_en & (count_q != 2'd2);
    assign O_push        = push_q;
    assign O_row_q       = row_q;
    assign O_slot        = slot_q;
    assign O_block_first = first_q;
    assign O_block_last  = last_q;
    assign O_block_done  = done_q;
    assign O_busy        = (count_q != 2'd0) | (state_q == SHIFT);

    // An incoming row may bypass an empty FIFO so it is issued the next cycle.
    always_comb begin
        accept  = I_en & I_row_valid & O_row_ready;
        issue   = I_en & ((count_q != 2'd0) | accept) &
                  ((state_q == IDLE) | (slot_q == 3'd7));
        head    = (count_q != 2'd0) ? mem_q[rd_ptr_q] : I_row_d;
        bypass  = accept & issue & (count_q == 2'd0);
        fifo_wr = accept & ~bypass;
        fifo_rd = issue & (count_q != 2'd0);

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = I_row_d;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (fifo_rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (fifo_wr && !fifo_rd) begin
            count_d = count_q + 2'd1;
        end else if (!fifo_wr && fifo_rd) begin
            count_d = count_q - 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        cur_last_d = cur_last_q;
        push_d     = push_q;
        row_d      = row_q;
        slot_d     = slot_q;
        first_d    = first_q;
        last_d     = last_q;
        done_d     = done_q;
        if (I_en) begin
            push_d  = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            done_d  = (state_q == SHIFT) && (slot_q == 3'd7) && cur_last_q;
            if (issue) begin
                push_d     = 1'b1;
                row_d      = head;
                slot_d     = 3'd0;
                state_d    = SHIFT;
                first_d    = (row_cnt_q == 3'd0);
                last_d     = (row_cnt_q == LAST_ROW);
                cur_last_d = (row_cnt_q == LAST_ROW);
                row_cnt_d  = (row_cnt_q == LAST_ROW) ? 3'd0 : row_cnt_q + 3'd1;
            end else if (state_q == SHIFT) begin
                if (slot_q == 3'd7) begin
                    state_d = IDLE;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= IDLE;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            row_cnt_q  <= 3'd0;
            cur_last_q <= 1'b0;
            push_q     <= 1'b0;
            row_q      <= '0;
            slot_q     <= 3'd0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            row_cnt_q  <= row_cnt_d;
            cur_last_q <= cur_last_d;
            push_q     <= push_d;
            row_q      <= row_d;
            slot_q     <= slot_d;
            first_q    <= first_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_p2s_row_scheduler.sv
// Randomized scoreboard bench for p2s_row_scheduler with a cycle-level
// reference model of row order, push timing, slot count and block flags.
module tb_p2s_row_scheduler;

    localparam int DW = 16;
    localparam int RW = 8 * DW;

    typedef struct {
        logic [RW-1:0] d;
        logic          first;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          row_valid;
    logic [RW-1:0] row_d;
    logic          row_ready;
    logic          push;
    logic [RW-1:0] row_q;
    logic [2:0]    slot;
    logic          block_first;
    logic          block_last;
    logic          block_done;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t          sb[$];
    int            acc_idx   = 0;
    int            cyc       = 0;
    int            lp        = 0;
    int            done_due  = -100;
    bit            have_push = 0;
    bit            en_prev   = 0;
    logic          exp_push  = 0;
    logic          exp_done  = 0;
    logic          exp_first = 0;
    logic          exp_last  = 0;
    logic [RW-1:0] exp_rowq  = '0;

    p2s_row_scheduler #(.DATA_WIDTH(DW), .ROWS_PER_BLOCK(8)) dut (
        .I_clk         (clk),
        .I_rst_n       (rst_n),
        .I_en          (en),
        .I_row_valid   (row_valid),
        .I_row_d       (row_d),
        .O_row_ready   (row_ready),
        .O_push        (push),
        .O_row_q       (row_q),
        .O_slot        (slot),
        .O_block_first (block_first),
        .O_block_last  (block_last),
        .O_block_done  (block_done),
        .O_busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [RW-1:0] act,
                                input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    // Monitor: advance the model for the edge that just passed, then compare.
    always @(negedge clk) begin
        exp_t e;
        int   exp_slot;
        bit   exp_busy;
        if (!rst_n) begin
            check_output("rst_push", push, 0);
            check_output("rst_slot", slot, 0);
            check_output("rst_rowq", row_q, 0);
            check_output("rst_busy", busy, 0);
            check_output("rst_ready", row_ready, 0);
            check_output("rst_done", block_done, 0);
            sb.delete();
            acc_idx   = 0;
            have_push = 0;
            done_due  = -100;
            exp_push  = 0;
            exp_done  = 0;
            exp_first = 0;
            exp_last  = 0;
            exp_rowq  = '0;
            en_prev   = 0;
        end else begin
            if (en_prev) begin
                cyc++;
                exp_push = (sb.size() > 0) && (!have_push || (cyc - lp >= 8));
                exp_done = (cyc == done_due);
                exp_first = 0;
                exp_last  = 0;
                if (exp_push) begin
                    e = sb.pop_front();
                    exp_rowq  = e.d;
                    exp_first = e.first;
                    exp_last  = e.last;
                    lp        = cyc;
                    have_push = 1;
                    if (e.last) done_due = cyc + 8;
                end
            end
            exp_slot = !have_push ? 0 : ((cyc - lp > 7) ? 7 : cyc - lp);
            exp_busy = (sb.size() != 0) || (have_push && (cyc - lp <= 7));
            check_output("push", push, exp_push);
            check_output("row_q", row_q, exp_rowq);
            check_output("block_first", block_first, exp_first);
            check_output("block_last", block_last, exp_last);
            check_output("block_done", block_done, exp_done);
            check_output("slot", slot, exp_slot);
            check_output("busy", busy, exp_busy);
            check_output("ready", row_ready, en && (sb.size() < 2));
            if (en && row_valid && row_ready) begin
                e.d     = row_d;
                e.first = (acc_idx % 8 == 0);
                e.last  = (acc_idx % 8 == 7);
                sb.push_back(e);
                acc_idx++;
            end
            en_prev = en;
        end
    end

    task automatic apply_stimulus(input int cycles, input int en_pct, input int valid_pct);
        for (int i = 0; i < cycles; i++) begin
            en        = ($urandom_range(0, 99) < en_pct);
            row_valid = ($urandom_range(0, 99) < valid_pct);
            row_d     = rand_row();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [RW-1:0] seq_row;
        rst_n     = 1'b0;
        en        = 1'b0;
        row_valid = 1'b0;
        row_d     = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single row 0x0001..0x0008, then let it drain to IDLE.
        for (int k = 0; k < 8; k++) seq_row[k*DW +: DW] = DW'(k + 1);
        en        = 1'b1;
        row_valid = 1'b1;
        row_d     = seq_row;
        @(posedge clk); #1;
        row_valid = 1'b0;
        apply_stimulus(12, 100, 0);

        // Continuous upstream valid covering two full blocks.
        apply_stimulus(140, 100, 100);
        apply_stimulus(12, 100, 0);

        // Five-cycle enable freeze starting at slot 3.
        en        = 1'b1;
        row_valid = 1'b1;
        for (int i = 0; i < 40 && slot != 3'd3; i++) begin
            row_d = rand_row();
            @(posedge clk); #1;
        end
        check_output("freeze_reach_slot3", slot == 3'd3, 1);
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        apply_stimulus(30, 100, 100);

        // Random enable/valid mix.
        apply_stimulus(150, 85, 60);

        // Reset mid-block with the FIFO full.
        apply_stimulus(45, 100, 100);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_output("async_push", push, 0);
        check_output("async_slot", slot, 0);
        check_output("async_rowq", row_q, 0);
        check_output("async_busy", busy, 0);
        check_output("async_ready", row_ready, 0);
        check_output("async_first", block_first, 0);
        en        = 1'b0;
        row_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(30, 100, 100);
        apply_stimulus(20, 100, 0);

        @(negedge clk); #1;
        check_output("drain_empty", sb.size(), 0);
        check_output("drain_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
